shift_cmd_pipe: RTL

- Registered, handshaked front-end and back-end wrapped around the 8-bit bidirectional logical shifter datapath.
- Accepts shift commands (operand, amount, direction) over valid/ready and presents the registered result, zero flag and carry-out over valid/ready.
- Two-stage pipeline: stage 1 holds the command, stage 2 holds the result. Full throughput of one command per cycle when there is no backpressure.

---
 rtl/shift_pkg.sv | 36 +++
 rtl/lshift_core.sv | 31 +++
 rtl/shift_cmd_pipe.sv | 127 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and helpers for the shift command pipeline.
//   DATA_W / AMT_W : datapath width and shift-amount width
//   shift_cmd_t    : one shift command {data, amt, right}
//   DIR_LEFT/RIGHT : encodings of the direction bit
//   shift_carry()  : last bit shifted out of a command's operand
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int AMT_W  = $clog2(DATA_W);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              right;
  } shift_cmd_t;

  // Carry is the last bit to leave the operand: data[k-1] for a right shift,
  // data[WIDTH-k] for a left shift, and 0 when nothing is shifted.
  // 0 - amt in AMT_W bits wraps to DATA_W - amt because DATA_W is a power of two.
  function automatic logic shift_carry(input shift_cmd_t cmd);
    logic carry;
    carry = 1'b0;
    if (cmd.amt == {AMT_W{1'b0}}) begin
      carry = 1'b0;
    end else if (cmd.right == DIR_RIGHT) begin
      carry = cmd.data[cmd.amt - AMT_W'(1)];
    end else begin
      carry = cmd.data[AMT_W'(0) - cmd.amt];
    end
    return carry;
  endfunction

endpackage

// File: rtl/lshift_core.sv
// Combinational logical shifter (zero fill, no rotate).
//   data  : operand
//   amt   : shift amount, 0..DATA_W-1
//   right : 1 = logical right, 0 = logical left
//   out   : shifted operand
//   carry : last bit shifted out, 0 when amt is 0
module lshift_core
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic              right,
  output logic [DATA_W-1:0] out,
  output logic              carry
);

  shift_cmd_t cmd_s;

  // Shift the operand and pick the departing bit as carry.
  always_comb begin
    cmd_s = '{data: data, amt: amt, right: right};
    out   = {DATA_W{1'b0}};
    if (right == DIR_RIGHT) begin
      out = data >> amt;
    end else begin
      out = data << amt;
    end
    carry = shift_carry(cmd_s);
  end

endmodule

// File: rtl/shift_cmd_pipe.sv
// Two-stage valid/ready pipeline around lshift_core.
// Stage 1 registers the incoming command, stage 2 registers the shifted
// result with its zero flag and carry.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clear               : synchronous flush of both stages (data kept)
//   in_valid/in_ready   : command handshake; in_data, in_amt, in_right
//   out_valid/out_ready : result handshake; out_data, out_zero, out_carry
//   busy                : any stage holds a command
module shift_cmd_pipe
  import shift_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic             in_right,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic             out_carry,
  output logic             busy
);

  shift_cmd_t       s1_cmd_q, s1_cmd_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_data_q, s2_data_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_carry_q, s2_carry_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             load2;
  logic [WIDTH-1:0] core_out;
  logic             core_carry;

  lshift_core u_core (
    .data  (s1_cmd_q.data),
    .amt   (s1_cmd_q.amt),
    .right (s1_cmd_q.right),
    .out   (core_out),
    .carry (core_carry)
  );

  // Handshake: a stage may advance when it is empty or its consumer drains it.
  // in_ready includes rst_n so nothing is accepted while reset is asserted.
  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = !s1_valid_q | s2_adv;
    in_ready = s1_adv & rst_n & !clear;
    accept   = in_valid & in_ready;
    load2    = s1_valid_q & s2_adv & !clear;
  end

  // Stage 1 next state: capture on accept, otherwise empty out when drained.
  always_comb begin
    s1_cmd_d   = s1_cmd_q;
    s1_valid_d = s1_valid_q;
    if (clear) begin
      s1_valid_d = 1'b0;
    end else if (accept) begin
      s1_valid_d = 1'b1;
      s1_cmd_d   = '{data: in_data, amt: in_amt, right: in_right};
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: load the shifter result, otherwise empty out when taken.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_zero_d  = s2_zero_q;
    s2_carry_d = s2_carry_q;
    if (clear) begin
      s2_valid_d = 1'b0;
    end else if (load2) begin
      s2_valid_d = 1'b1;
      s2_data_d  = core_out;
      s2_zero_d  = (core_out == {WIDTH{1'b0}});
      s2_carry_d = core_carry;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_cmd_q   <= '{data: {DATA_W{1'b0}}, amt: {AMT_W{1'b0}}, right: 1'b0};
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= {WIDTH{1'b0}};
      s2_zero_q  <= 1'b0;
      s2_carry_q <= 1'b0;
    end else begin
      s1_cmd_q   <= s1_cmd_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_zero_q  <= s2_zero_d;
      s2_carry_q <= s2_carry_d;
    end
  end

  // Outputs come straight from the stage registers.
  always_comb begin
    out_valid = s2_valid_q;
    out_data  = s2_data_q;
    out_zero  = s2_zero_q;
    out_carry = s2_carry_q;
    busy      = s1_valid_q | s2_valid_q;
  end

endmodule
